// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
//
// Contents:
//   state_t            sequencer state (RUN, FLUSH, MC_WAIT), 2-bit encoding
//   FLUSH_CYCLES_DEF   default number of bubble cycles after a redirect
//   FLUSH_CTR_W        width of the flush-window down-counter (holds up to 15)
//   REG_X0             architectural zero register index

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MC_WAIT = 2'd2
    } state_t;

    localparam int          FLUSH_CYCLES_DEF = 2;
    localparam int          FLUSH_CTR_W      = 4;
    localparam logic [4:0]  REG_X0           = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
//
// Ports:
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2   instruction in ID and its source operands
//   ex_valid, ex_rd, ex_is_load                        instruction in EX and its destination
//   hazard                                             ID reads a register the EX load has not yet returned

module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_valid,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;
    logic load_live;

    // x0 is hardwired to zero, so a load targeting it never produces a value to wait for.
    assign load_live = ex_valid && ex_is_load && (ex_rd != REG_X0);
    assign rs1_hit   = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit   = id_use_rs2 && (id_rs2 == ex_rd);
    assign hazard    = id_valid && load_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline front end
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   id_*                            ID-stage instruction and the registers it reads
//   ex_valid, ex_rd, ex_is_load     EX-stage instruction, used for load-use detection
//   ex_redirect, ex_target          taken branch/jump resolved in EX and its target
//   ex_mc_start, ex_mc_done         multi-cycle EX operation start / completion
//   jmp, jmp_pc                     redirect strobe and PC to IFetch
//   pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush   pipeline register controls
//   mc_kill                         abort the in-flight multi-cycle operation
//   busy                            sequencer is outside RUN
//   stall_cnt, flush_cnt            free-running counts of pc_stall / if_id_flush cycles

module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_target,
    input  logic             ex_mc_start,
    input  logic             ex_mc_done,
    output logic             jmp,
    output logic [31:0]      jmp_pc,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             mc_kill,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The redirect cycle itself is the first bubble, so the FLUSH state only
    // covers the remaining FLUSH_CYCLES-1 cycles. With a one-cycle window
    // there is nothing left to cover and the sequencer stays in RUN.
    localparam logic [FLUSH_CTR_W-1:0] FLUSH_RELOAD   = FLUSH_CTR_W'(FLUSH_CYCLES - 1);
    localparam state_t                 REDIRECT_NEXT  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t                 state;
    state_t                 state_next;
    logic [FLUSH_CTR_W-1:0] flush_ctr;
    logic [FLUSH_CTR_W-1:0] flush_ctr_next;

    logic hazard;
    logic redirect;
    logic mc_start;

    logic if_id_stall_raw;
    logic id_ex_stall_raw;

    load_use_detect u_load_use_detect (
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_valid   (ex_valid),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .hazard     (hazard)
    );

    // Only a valid EX instruction may redirect or start a multi-cycle op.
    assign redirect = ex_redirect && ex_valid;
    assign mc_start = ex_mc_start && ex_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            flush_ctr <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_ctr <= flush_ctr_next;
            if (pc_stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next      = state;
        flush_ctr_next  = flush_ctr;
        jmp             = 1'b0;
        jmp_pc          = '0;
        pc_stall        = 1'b0;
        if_id_stall_raw = 1'b0;
        id_ex_stall_raw = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        mc_kill         = 1'b0;

        unique case (state)
            RUN: begin
                if (redirect) begin
                    jmp            = 1'b1;
                    jmp_pc         = ex_target;
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                    flush_ctr_next = FLUSH_RELOAD;
                    state_next     = REDIRECT_NEXT;
                end else if (mc_start) begin
                    pc_stall        = 1'b1;
                    if_id_stall_raw = 1'b1;
                    id_ex_stall_raw = 1'b1;
                    // A zero-wait operation finishes in its start cycle.
                    if (!ex_mc_done) begin
                        state_next = MC_WAIT;
                    end
                end else if (hazard) begin
                    // One bubble is enough: the load moves to MEM next cycle
                    // and the forwarding path covers the rest.
                    pc_stall        = 1'b1;
                    if_id_stall_raw = 1'b1;
                    id_ex_flush     = 1'b1;
                end
            end

            FLUSH: begin
                // Fetch runs from the new target; whatever reaches IF/ID or
                // ID/EX in this window is wrong-path and gets squashed.
                // Load-use is deliberately ignored here.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (redirect) begin
                    jmp            = 1'b1;
                    jmp_pc         = ex_target;
                    flush_ctr_next = FLUSH_RELOAD;
                    state_next     = REDIRECT_NEXT;
                end else if (flush_ctr <= FLUSH_CTR_W'(1)) begin
                    flush_ctr_next = '0;
                    state_next     = RUN;
                end else begin
                    flush_ctr_next = flush_ctr - FLUSH_CTR_W'(1);
                end
            end

            MC_WAIT: begin
                if (redirect) begin
                    // An older instruction is trapping: throw away the
                    // multi-cycle op and redirect exactly as from RUN.
                    mc_kill        = 1'b1;
                    jmp            = 1'b1;
                    jmp_pc         = ex_target;
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                    flush_ctr_next = FLUSH_RELOAD;
                    state_next     = REDIRECT_NEXT;
                end else begin
                    pc_stall        = 1'b1;
                    if_id_stall_raw = 1'b1;
                    id_ex_stall_raw = 1'b1;
                    if (ex_mc_done) begin
                        state_next = RUN;
                    end
                end
            end

            default: begin
                state_next     = RUN;
                flush_ctr_next = '0;
            end
        endcase

        // While reset is held both pipeline registers are cleared to bubbles
        // and nothing else is driven, whatever the inputs say.
        if (reset) begin
            jmp             = 1'b0;
            jmp_pc          = '0;
            pc_stall        = 1'b0;
            if_id_stall_raw = 1'b0;
            id_ex_stall_raw = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            mc_kill         = 1'b0;
        end
    end

    // A register is never held and cleared together; clearing wins.
    assign if_id_stall = if_id_stall_raw && !if_id_flush;
    assign id_ex_stall = id_ex_stall_raw && !id_ex_flush;

    assign busy = (state != RUN);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed table-driven bench for pipeline_ctrl

module tb_pipeline_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        ex_mc_start;
    logic        ex_mc_done;
    logic        jmp;
    logic [31:0] jmp_pc;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_stall;
    logic        id_ex_flush;
    logic        mc_kill;
    logic        busy;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int tests_run;
    int tests_failed;

    pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .ex_mc_start (ex_mc_start),
        .ex_mc_done  (ex_mc_done),
        .jmp         (jmp),
        .jmp_pc      (jmp_pc),
        .pc_stall    (pc_stall),
        .if_id_stall (if_id_stall),
        .if_id_flush (if_id_flush),
        .id_ex_stall (id_ex_stall),
        .id_ex_flush (id_ex_flush),
        .mc_kill     (mc_kill),
        .busy        (busy),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bits packed as {jmp, pc_stall, if_id_stall, if_id_flush,
    //                         id_ex_stall, id_ex_flush, mc_kill, busy}
    localparam logic [7:0] C_IDLE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b0110_0100;
    localparam logic [7:0] C_RD   = 8'b1001_0100;
    localparam logic [7:0] C_FL   = 8'b0001_0101;
    localparam logic [7:0] C_MCS  = 8'b0110_1000;
    localparam logic [7:0] C_MCW  = 8'b0110_1001;
    localparam logic [7:0] C_KILL = 8'b1001_0111;
    localparam logic [7:0] C_RST  = 8'b0001_0100;

    typedef struct {
        logic        idv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        exv;
        logic [4:0]  rd;
        logic        ld;
        logic        rdr;
        logic [31:0] tgt;
        logic        mcs;
        logic        mcd;
        logic [7:0]  ctl;
        logic [31:0] pc;
        int          s;
        int          f;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic exv,
                                input logic [4:0] rd, input logic ld, input logic rdr,
                                input logic [31:0] tgt, input logic mcs, input logic mcd,
                                input logic [7:0] ctl, input logic [31:0] pc, input int s, input int f);
        vec_t v;
        v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exv = exv; v.rd = rd; v.ld = ld; v.rdr = rdr; v.tgt = tgt;
        v.mcs = mcs; v.mcd = mcd; v.ctl = ctl; v.pc = pc; v.s = s; v.f = f;
        return v;
    endfunction

    function automatic logic [7:0] ctl_now();
        return {jmp, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, mc_kill, busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid    = v.idv;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_use_rs1  = v.u1;
        id_use_rs2  = v.u2;
        ex_valid    = v.exv;
        ex_rd       = v.rd;
        ex_is_load  = v.ld;
        ex_redirect = v.rdr;
        ex_target   = v.tgt;
        ex_mc_start = v.mcs;
        ex_mc_done  = v.mcd;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, C_IDLE, 32'h0, 0, 0));
    endtask

    // Cycle step: inputs change at the falling edge, outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int s0;
        int f0;
        int n_stall;
        int n_busy;

        tests_run    = 0;
        tests_failed = 0;

        //           idv rs1 rs2 u1 u2 exv rd ld rdr tgt       mcs mcd ctl     pc        s  f
        vecs[0]  = mk(0, 0,  0,  0, 0, 0,  0, 0, 0, 32'h0,    0, 0, C_IDLE, 32'h0,   0, 0);
        vecs[1]  = mk(1, 3,  5,  1, 1, 1,  5, 1, 0, 32'h0,    0, 0, C_LU,   32'h0,   0, 0);
        vecs[2]  = mk(1, 0,  0,  1, 1, 1,  0, 1, 0, 32'h0,    0, 0, C_IDLE, 32'h0,   1, 0);
        vecs[3]  = mk(1, 7,  2,  0, 1, 1,  7, 1, 0, 32'h0,    0, 0, C_IDLE, 32'h0,   1, 0);
        vecs[4]  = mk(1, 7,  2,  1, 0, 1,  7, 1, 0, 32'h0,    0, 0, C_LU,   32'h0,   1, 0);
        vecs[5]  = mk(0, 0,  0,  0, 0, 1,  0, 0, 1, 32'h100,  0, 0, C_RD,   32'h100, 2, 0);
        vecs[6]  = mk(0, 0,  0,  0, 0, 0,  0, 0, 0, 32'h0,    0, 0, C_FL,   32'h0,   2, 1);
        vecs[7]  = mk(0, 0,  0,  0, 0, 0,  0, 0, 0, 32'h0,    0, 0, C_IDLE, 32'h0,   2, 2);
        vecs[8]  = mk(0, 0,  0,  0, 0, 1,  0, 0, 0, 32'h0,    1, 0, C_MCS,  32'h0,   2, 2);
        vecs[9]  = mk(0, 0,  0,  0, 0, 0,  0, 0, 0, 32'h0,    0, 0, C_MCW,  32'h0,   3, 2);
        vecs[10] = mk(0, 0,  0,  0, 0, 0,  0, 0, 0, 32'h0,    0, 1, C_MCW,  32'h0,   4, 2);
        vecs[11] = mk(0, 0,  0,  0, 0, 0,  0, 0, 0, 32'h0,    0, 0, C_IDLE, 32'h0,   5, 2);
        vecs[12] = mk(0, 0,  0,  0, 0, 1,  0, 0, 0, 32'h0,    1, 1, C_MCS,  32'h0,   5, 2);
        vecs[13] = mk(0, 0,  0,  0, 0, 0,  0, 0, 0, 32'h0,    0, 0, C_IDLE, 32'h0,   6, 2);
        vecs[14] = mk(0, 0,  0,  0, 0, 0,  0, 0, 1, 32'h140,  0, 0, C_IDLE, 32'h0,   6, 2);
        vecs[15] = mk(1, 9,  0,  1, 0, 1,  9, 1, 1, 32'h180,  0, 0, C_RD,   32'h180, 6, 2);
        vecs[16] = mk(1, 9,  0,  1, 0, 1,  9, 1, 0, 32'h0,    0, 0, C_FL,   32'h0,   6, 3);
        vecs[17] = mk(0, 0,  0,  0, 0, 0,  0, 0, 0, 32'h0,    0, 0, C_IDLE, 32'h0,   6, 4);

        // Reset held for three cycles with a redirect and mc_start on the inputs.
        reset = 1'b1;
        drive(mk(1, 5, 5, 1, 1, 1, 5, 1, 1, 32'h44, 1, 0, C_IDLE, 32'h0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            chk($sformatf("reset c%0d ctl", c), {24'd0, ctl_now()}, {24'd0, C_RST});
            chk($sformatf("reset c%0d jmp_pc", c), jmp_pc, 32'h0);
        end
        step();
        reset = 1'b0;
        idle();
        #1;
        chk("post-reset ctl", {24'd0, ctl_now()}, {24'd0, C_IDLE});
        chk("post-reset stall_cnt", stall_cnt, 32'd0);
        chk("post-reset flush_cnt", flush_cnt, 32'd0);

        // Table: one vector per cycle, outputs checked combinationally.
        for (int i = 0; i < 18; i++) begin
            step();
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d ctl", i), {24'd0, ctl_now()}, {24'd0, vecs[i].ctl});
            chk($sformatf("v%0d jmp_pc", i), jmp_pc, vecs[i].pc);
            chk($sformatf("v%0d stall_cnt", i), stall_cnt, 32'(vecs[i].s));
            chk($sformatf("v%0d flush_cnt", i), flush_cnt, 32'(vecs[i].f));
        end

        // Multi-cycle op, done four cycles after start: 5 stall cycles, 4 busy.
        step();
        idle();
        #1;
        s0 = int'(stall_cnt);
        n_stall = 0;
        n_busy  = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            idle();
            ex_valid    = (c == 0);
            ex_mc_start = (c == 0);
            ex_mc_done  = (c == 4);
            #1;
            if (pc_stall && if_id_stall && id_ex_stall) n_stall++;
            if (busy) n_busy++;
        end
        chk("mc4 stall cycles", 32'(n_stall), 32'd5);
        chk("mc4 busy cycles", 32'(n_busy), 32'd4);
        chk("mc4 stall_cnt delta", stall_cnt - 32'(s0), 32'd5);

        // Redirect while in MC_WAIT kills the op; load-use in FLUSH is ignored.
        step();
        idle();
        ex_valid = 1'b1; ex_mc_start = 1'b1;
        step();
        idle();
        ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 32'h200;
        #1;
        chk("mcw redirect ctl", {24'd0, ctl_now()}, {24'd0, C_KILL});
        chk("mcw redirect jmp_pc", jmp_pc, 32'h200);
        step();
        drive(vecs[16]);
        #1;
        chk("mcw flush ctl", {24'd0, ctl_now()}, {24'd0, C_FL});
        step();
        idle();
        #1;
        chk("mcw back to run", {24'd0, ctl_now()}, {24'd0, C_IDLE});

        // Redirect re-fired during FLUSH reloads the window.
        f0 = int'(flush_cnt);
        step();
        idle();
        ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 32'h300;
        #1;
        chk("refire first ctl", {24'd0, ctl_now()}, {24'd0, C_RD});
        step();
        idle();
        ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 32'h340;
        #1;
        chk("refire second ctl", {24'd0, ctl_now()}, {24'd0, C_RD | C_FL});
        chk("refire second jmp_pc", jmp_pc, 32'h340);
        step();
        idle();
        #1;
        chk("refire tail ctl", {24'd0, ctl_now()}, {24'd0, C_FL});
        step();
        idle();
        #1;
        chk("refire run ctl", {24'd0, ctl_now()}, {24'd0, C_IDLE});
        chk("refire flush_cnt delta", flush_cnt - 32'(f0), 32'd3);

        // Reset in the middle of MC_WAIT: no kill pulse, straight back to RUN.
        step();
        idle();
        ex_valid = 1'b1; ex_mc_start = 1'b1;
        step();
        idle();
        #1;
        chk("pre-reset mcw busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid-reset ctl", {24'd0, ctl_now()}, {24'd0, C_RST});
        step();
        reset = 1'b0;
        #1;
        chk("after mid-reset ctl", {24'd0, ctl_now()}, {24'd0, C_IDLE});
        chk("after mid-reset stall_cnt", stall_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32IC pipeline, sitting beside IFetch, decoder and the ID/EX register.
- Detects load-use hazards.
- Sequences control-transfer redirects into a fixed flush window.
- Freezes the front end while a multi-cycle EX operation (divide, misaligned load split) runs.
- Keeps stall/flush performance counters.

Parameters:
FLUSH_CYCLES, 2, bubble cycles inserted after a redirect (range 1..15)
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a valid instruction
id_rs1  input  5  ID source register 1
id_rs2  input  5  ID source register 2
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_valid  input  1  EX stage holds a valid instruction
ex_rd  input  5  EX destination register
ex_is_load  input  1  EX instruction is a load
ex_redirect  input  1  EX resolved a taken branch or jump
ex_target  input  32  redirect target PC
ex_mc_start  input  1  EX begins a multi-cycle operation
ex_mc_done  input  1  multi-cycle operation completes this cycle
jmp  output  1  redirect strobe to IFetch
jmp_pc  output  32  redirect PC to IFetch
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID register
if_id_flush  output  1  clear IF/ID register to a bubble
id_ex_stall  output  1  hold ID/EX register
id_ex_flush  output  1  insert a bubble into ID/EX
mc_kill  output  1  abort the in-flight multi-cycle operation
busy  output  1  FSM not in RUN
stall_cnt  output  CNT_W  cycles with pc_stall=1
flush_cnt  output  CNT_W  cycles with if_id_flush=1

Behaviour:
- Outputs are combinational from state plus current inputs. State and counters are registered.
- Reset asserted:
  - state=RUN, counters=0.
  - if_id_flush=1, id_ex_flush=1.
  - All other outputs 0; jmp_pc=0.
  - Reset mid-operation abandons FLUSH/MC_WAIT with no mc_kill pulse.
- Load-use condition: id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - x0 never hazards.
- Priority, highest first: redirect > multi-cycle > load-use.
- RUN:
  - ex_redirect & ex_valid → same cycle: jmp=1, jmp_pc=ex_target, if_id_flush=1, id_ex_flush=1. Next state FLUSH, counter=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, stay in RUN.
  - else ex_mc_start & ex_valid → pc_stall, if_id_stall, id_ex_stall =1. Next state MC_WAIT. If ex_mc_done is already 1 this cycle, stay in RUN (stall for exactly this cycle).
  - else load-use → pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle. State stays RUN; the hazard clears as the load advances.
  - else all control outputs 0.
- FLUSH:
  - if_id_flush=1, id_ex_flush=1, pc_stall=0 (fetching proceeds from the target).
  - Counter decrements; leave to RUN when counter=0.
  - Load-use is suppressed in FLUSH.
  - A new ex_redirect in FLUSH re-asserts jmp/jmp_pc and reloads the counter to FLUSH_CYCLES-1.
- MC_WAIT:
  - pc_stall, if_id_stall, id_ex_stall =1 each cycle.
  - ex_mc_done → stalls still asserted that cycle; RUN next.
  - ex_redirect in MC_WAIT (older instruction in MEM forcing a trap) → mc_kill=1 for one cycle, redirect handled as from RUN, next state FLUSH.
- busy=1 whenever state≠RUN.
- Counters increment by 1 per qualifying cycle and wrap modulo 2^CNT_W.
- Invariant: a register is never stalled and flushed in the same cycle. Flush wins.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum (RUN, FLUSH, MC_WAIT), 2-bit encoding
  - FLUSH_CYCLES default constant
  - REG_X0 constant
- Sub-module load_use_detect: purely combinational comparator producing the hazard bit.
- FSM and counters stay in pipeline_ctrl.

Test Plan:
- Reset held 3 cycles, then released → if_id_flush=id_ex_flush=1 during reset; afterwards all control outputs 0, stall_cnt=flush_cnt=0, busy=0.
- EX load with ex_rd=5; ID instruction with id_rs2=5, id_use_rs2=1 → exactly one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cnt=1. Repeat with ex_rd=0 → no stall.
- ex_redirect with ex_target=0x0000_0100, FLUSH_CYCLES=2 → jmp=1, jmp_pc=0x100 for one cycle; flushes asserted for 2 cycles total; flush_cnt=2; RUN afterwards.
- ex_mc_start, then ex_mc_done 4 cycles later → pc_stall=if_id_stall=id_ex_stall=1 for 5 cycles; busy=1 for 4 cycles; stall_cnt=5.
- In MC_WAIT, ex_redirect with target 0x200 → mc_kill pulse, jmp_pc=0x200, FLUSH entered; a load-use presented during FLUSH → ignored.
- Redirect and load-use in the same cycle, and redirect re-fired during FLUSH → redirect wins; counter reloads so flush lasts FLUSH_CYCLES from the last redirect.
